// File: rtl/alu_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arb_pkg : types and constants for the two-port ALU arbiter      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_arb_pkg;

  typedef logic [0:0] port_idx_t;

  localparam int C_NUM_PORTS   = 2;
  localparam int C_NUM_ALU_OPS = 9;

  function automatic logic op_defined(input logic [3:0] op);
    return int'(op) < C_NUM_ALU_OPS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_defs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_defs_pkg : ALU operation codes shared by the ALU and its users  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_defs_pkg;

  // Defined codes are packed contiguously from zero; anything above SLTU is illegal.
  localparam logic [3:0] C_ALU_ADD  = 4'd0;
  localparam logic [3:0] C_ALU_SUB  = 4'd1;
  localparam logic [3:0] C_ALU_AND  = 4'd2;
  localparam logic [3:0] C_ALU_OR   = 4'd3;
  localparam logic [3:0] C_ALU_XOR  = 4'd4;
  localparam logic [3:0] C_ALU_SLL  = 4'd5;
  localparam logic [3:0] C_ALU_SR   = 4'd6;
  localparam logic [3:0] C_ALU_SLT  = 4'd7;
  localparam logic [3:0] C_ALU_SLTU = 4'd8;

endpackage
`default_nettype wire

// File: rtl/alu_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arb_if : one requester port (request + response handshakes)     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alu_arb_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [3:0]  req_ctrl;
  logic        req_ext;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_src1, req_src2, req_ctrl, req_ext, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_src1, req_src2, req_ctrl, req_ext, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/alu_arb_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arb_alu : combinational 32-bit ALU with illegal-op flag         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_arb_alu
  import alu_defs_pkg::*;
  import alu_arb_pkg::*;
(
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [3:0]  ctrl,
  input  logic        ext,
  output logic [31:0] res,
  output logic        err
);

  logic [31:0] w_diff;
  logic [31:0] w_sra;
  logic [4:0]  w_shamt;

  assign w_shamt = src2[4:0];
  assign w_diff  = src1 - src2;
  // Kept as its own assignment so the arithmetic shift stays in a signed context.
  assign w_sra   = $signed(src1) >>> w_shamt;
  assign err     = ~op_defined(ctrl);

  always_comb begin
    res = 32'h0;
    case (ctrl)
      C_ALU_ADD:  res = src1 + src2;
      C_ALU_SUB:  res = w_diff;
      C_ALU_AND:  res = src1 & src2;
      C_ALU_OR:   res = src1 | src2;
      C_ALU_XOR:  res = src1 ^ src2;
      C_ALU_SLL:  res = src1 << w_shamt;
      C_ALU_SR:   res = ext ? w_sra : (src1 >> w_shamt);
      C_ALU_SLT:  res = {31'h0, w_diff[31]};
      C_ALU_SLTU: res = {31'h0, (src1 < src2)};
      default:    res = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arb : two requesters share one ALU; per-port 1-deep result slot |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
)
(
  input  logic      clk,
  input  logic      rst,
  alu_arb_if.slave  port0,
  alu_arb_if.slave  port1
);

  logic [C_NUM_PORTS-1:0]       w_req_valid;
  logic [C_NUM_PORTS-1:0]       w_rsp_ready;
  logic [C_NUM_PORTS-1:0]       w_ext;
  logic [C_NUM_PORTS-1:0][31:0] w_src1;
  logic [C_NUM_PORTS-1:0][31:0] w_src2;
  logic [C_NUM_PORTS-1:0][3:0]  w_ctrl;
  logic [C_NUM_PORTS-1:0]       w_elig;
  logic [C_NUM_PORTS-1:0]       w_gnt;
  port_idx_t                    w_sel;
  logic [31:0]                  w_alu_res;
  logic                         w_alu_err;

  logic [C_NUM_PORTS-1:0]       r_rsp_valid;
  logic [C_NUM_PORTS-1:0]       r_rsp_err;
  logic [C_NUM_PORTS-1:0][31:0] r_rsp_data;
  port_idx_t                    r_ptr;

  assign w_req_valid = {port1.req_valid, port0.req_valid};
  assign w_rsp_ready = {port1.rsp_ready, port0.rsp_ready};
  assign w_ext       = {port1.req_ext,   port0.req_ext};
  assign w_src1      = {port1.req_src1,  port0.req_src1};
  assign w_src2      = {port1.req_src2,  port0.req_src2};
  assign w_ctrl      = {port1.req_ctrl,  port0.req_ctrl};

  // Grant depends only on valids and slot occupancy, never on operands.
  always_comb begin
    w_elig = w_req_valid & (~r_rsp_valid | w_rsp_ready) & {C_NUM_PORTS{~rst}};
    w_gnt  = w_elig;
    if (&w_elig) begin
      w_gnt        = '0;
      w_gnt[r_ptr] = 1'b1;
    end
  end

  assign w_sel = port_idx_t'(w_gnt[1]);

  alu_arb_alu u_alu (
    .src1 (w_src1[w_sel]),
    .src2 (w_src2[w_sel]),
    .ctrl (w_ctrl[w_sel]),
    .ext  (w_ext[w_sel]),
    .res  (w_alu_res),
    .err  (w_alu_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_err   <= '0;
      r_rsp_data  <= '0;
      r_ptr       <= '0;
    end else begin
      for (int i = 0; i < C_NUM_PORTS; i++) begin
        if (w_gnt[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_data[i]  <= w_alu_res;
          r_rsp_err[i]   <= w_alu_err;
        end else if (w_rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
      if (RR_EN && (|w_gnt)) begin
        r_ptr <= ~r_ptr;
      end
    end
  end

  assign port0.req_ready = w_gnt[0];
  assign port1.req_ready = w_gnt[1];
  assign port0.rsp_valid = r_rsp_valid[0];
  assign port1.rsp_valid = r_rsp_valid[1];
  assign port0.rsp_data  = r_rsp_data[0];
  assign port1.rsp_data  = r_rsp_data[1];
  assign port0.rsp_err   = r_rsp_err[0];
  assign port1.rsp_err   = r_rsp_err[1];

endmodule
`default_nettype wire

// File: tb/tb_alu_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_arb : directed and random checks of alu_arb against a model  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_arb;
  import alu_defs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]       tv_valid  = '0;
  logic [1:0]       tv_rready = '0;
  logic [1:0]       tv_ext    = '0;
  logic [1:0][31:0] tv_s1     = '0;
  logic [1:0][31:0] tv_s2     = '0;
  logic [1:0][3:0]  tv_op     = '0;

  logic [1:0]       rr_rdy, rr_rvld, rr_rerr, fp_rdy;
  logic [1:0][31:0] rr_rdata;

  logic [1:0]       obs_rdy, obs_vld, obs_err, obs_fp_rdy;
  logic [1:0][31:0] obs_data;
  logic [1:0]       exp_rdy, exp_vld, exp_err;
  logic [1:0][31:0] exp_data;

  // Reference state: what each port's result slot holds, and who has priority.
  logic [1:0]       m_vld, m_err;
  logic [1:0][31:0] m_data;
  logic             m_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arb_if rr_if[2] ();
  alu_arb_if fp_if[2] ();

  for (genvar gi = 0; gi < 2; gi++) begin : g_drv
    assign rr_if[gi].req_valid = tv_valid[gi];
    assign rr_if[gi].req_src1  = tv_s1[gi];
    assign rr_if[gi].req_src2  = tv_s2[gi];
    assign rr_if[gi].req_ctrl  = tv_op[gi];
    assign rr_if[gi].req_ext   = tv_ext[gi];
    assign rr_if[gi].rsp_ready = tv_rready[gi];
    assign fp_if[gi].req_valid = tv_valid[gi];
    assign fp_if[gi].req_src1  = tv_s1[gi];
    assign fp_if[gi].req_src2  = tv_s2[gi];
    assign fp_if[gi].req_ctrl  = tv_op[gi];
    assign fp_if[gi].req_ext   = tv_ext[gi];
    assign fp_if[gi].rsp_ready = tv_rready[gi];
    assign rr_rdy[gi]   = rr_if[gi].req_ready;
    assign rr_rvld[gi]  = rr_if[gi].rsp_valid;
    assign rr_rdata[gi] = rr_if[gi].rsp_data;
    assign rr_rerr[gi]  = rr_if[gi].rsp_err;
    assign fp_rdy[gi]   = fp_if[gi].req_ready;
  end

  alu_arb #(.RR_EN(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .port0 (rr_if[0]),
    .port1 (rr_if[1])
  );

  alu_arb #(.RR_EN(1'b0)) dut_fp (
    .clk   (clk),
    .rst   (rst),
    .port0 (fp_if[0]),
    .port1 (fp_if[1])
  );

  function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic ext);
    logic [31:0] diff;
    logic [31:0] sra;
    int unsigned sh;
    diff = a - b;
    sh   = b % 32;
    sra  = $signed(a) >>> sh;
    case (op)
      C_ALU_ADD:  return {1'b0, a + b};
      C_ALU_SUB:  return {1'b0, diff};
      C_ALU_AND:  return {1'b0, a & b};
      C_ALU_OR:   return {1'b0, a | b};
      C_ALU_XOR:  return {1'b0, a ^ b};
      C_ALU_SLL:  return {1'b0, a << sh};
      C_ALU_SR:   return ext ? {1'b0, sra} : {1'b0, a >> sh};
      C_ALU_SLT:  return {1'b0, 31'h0, diff[31]};
      C_ALU_SLTU: return {1'b0, 31'h0, (a < b)};
      default:    return {1'b1, 32'h0};
    endcase
  endfunction

  // One clock: sample DUT and reference at negedge, then advance the reference on the edge.
  task automatic cycle();
    logic [1:0]  elig;
    logic [32:0] r;
    @(negedge clk);
    obs_rdy    = rr_rdy;
    obs_vld    = rr_rvld;
    obs_err    = rr_rerr;
    obs_data   = rr_rdata;
    obs_fp_rdy = fp_rdy;
    for (int i = 0; i < 2; i++)
      elig[i] = !rst && tv_valid[i] && (!m_vld[i] || tv_rready[i]);
    if (elig == 2'b11) exp_rdy = m_ptr ? 2'b10 : 2'b01;
    else               exp_rdy = elig;
    exp_vld  = m_vld;
    exp_err  = m_err;
    exp_data = m_data;
    @(posedge clk);
    if (rst) begin
      m_vld = '0; m_err = '0; m_data = '0; m_ptr = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (exp_rdy[i]) begin
          r = alu_ref(tv_op[i], tv_s1[i], tv_s2[i], tv_ext[i]);
          m_vld[i] = 1'b1; m_err[i] = r[32]; m_data[i] = r[31:0];
        end else if (m_vld[i] && tv_rready[i]) begin
          m_vld[i] = 1'b0;
        end
      end
      if (exp_rdy != 2'b00) m_ptr = !m_ptr;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tv_valid = '0; tv_rready = '0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tv_valid = 2'b11; tv_rready = 2'b11;
    cycle();
    cycle();
    n_checks++;
    if (obs_rdy !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", obs_rdy); end
    n_checks++;
    if (obs_fp_rdy !== 2'b00) begin n_fail++; $display("FAIL reset_ready_fp: got %b expected 00", obs_fp_rdy); end
    n_checks++;
    if (obs_vld !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b expected 00", obs_vld); end
    n_checks++;
    if (obs_data !== '0 || obs_err !== 2'b00) begin
      n_fail++; $display("FAIL reset_data: got %h err %b expected 0 err 00", obs_data, obs_err);
    end
    tv_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    tv_valid = 2'b01; tv_rready = 2'b01;
    tv_op[0] = C_ALU_ADD; tv_s1[0] = 32'd5; tv_s2[0] = 32'd7; tv_ext[0] = 1'b0;
    cycle();
    n_checks++;
    if (obs_rdy !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", obs_rdy); end
    tv_valid = 2'b00;
    cycle();
    n_checks++;
    if (obs_vld[0] !== 1'b1 || obs_data[0] !== 32'd12 || obs_err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_add: got v%b d%h e%b expected v1 d0000000c e0", obs_vld[0], obs_data[0], obs_err[0]);
    end
  endtask

  task automatic test_contention();
    do_reset();
    tv_valid = 2'b11; tv_rready = 2'b11;
    tv_op = {C_ALU_ADD, C_ALU_ADD}; tv_s1 = {32'd2, 32'd1}; tv_s2 = {32'd2, 32'd1}; tv_ext = '0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_checks++;
      if (obs_rdy !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, obs_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      n_checks++;
      if (obs_fp_rdy !== 2'b01) begin
        n_fail++; $display("FAIL fixed_grant[%0d]: got %b expected 01", k, obs_fp_rdy);
      end
    end
    tv_valid = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    tv_valid = 2'b10; tv_rready = 2'b00;
    tv_op[1] = C_ALU_SR; tv_s1[1] = 32'h8000_0000; tv_s2[1] = 32'd4; tv_ext[1] = 1'b1;
    cycle();
    n_checks++;
    if (obs_rdy !== 2'b10) begin n_fail++; $display("FAIL bp_first_grant: got %b expected 10", obs_rdy); end
    tv_ext[1] = 1'b0; tv_s1[1] = 32'h0000_00F0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++;
      if (obs_rdy[1] !== 1'b0 || obs_vld[1] !== 1'b1 || obs_data[1] !== 32'hF800_0000) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got r%b v%b d%h expected r0 v1 dF8000000", k, obs_rdy[1], obs_vld[1], obs_data[1]);
      end
    end
    tv_rready[1] = 1'b1;
    cycle();
    n_checks++;
    if (obs_rdy !== 2'b10) begin n_fail++; $display("FAIL bp_drain_grant: got %b expected 10", obs_rdy); end
    tv_op[1] = C_ALU_ADD; tv_s1[1] = 32'd3; tv_s2[1] = 32'd4;
    cycle();
    n_checks++;
    if (obs_rdy !== 2'b10 || obs_vld[1] !== 1'b1 || obs_data[1] !== 32'h0000_000F) begin
      n_fail++; $display("FAIL b2b_first: got r%b v%b d%h expected r10 v1 d0000000f", obs_rdy, obs_vld[1], obs_data[1]);
    end
    tv_valid = 2'b00;
    cycle();
    n_checks++;
    if (obs_vld[1] !== 1'b1 || obs_data[1] !== 32'd7) begin
      n_fail++; $display("FAIL b2b_second: got v%b d%h expected v1 d00000007", obs_vld[1], obs_data[1]);
    end
    cycle();
    n_checks++;
    if (obs_vld[1] !== 1'b0) begin n_fail++; $display("FAIL drain_clear: got %b expected 0", obs_vld[1]); end
  endtask

  task automatic test_edge_ops();
    logic [3:0]  ops [4] = '{C_ALU_SLT, C_ALU_SLTU, C_ALU_SUB, 4'hF};
    logic [31:0] as  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678};
    logic [31:0] bs  [4] = '{32'h1, 32'h1, 32'h1, 32'h1};
    logic [31:0] eds [4] = '{32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0};
    logic        ees [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    tv_rready = 2'b01;
    for (int k = 0; k < 4; k++) begin
      tv_valid = 2'b01; tv_op[0] = ops[k]; tv_s1[0] = as[k]; tv_s2[0] = bs[k]; tv_ext[0] = 1'b0;
      cycle();
      tv_valid = 2'b00;
      cycle();
      n_checks++;
      if (obs_vld[0] !== 1'b1 || obs_data[0] !== eds[k] || obs_err[0] !== ees[k]) begin
        n_fail++;
        $display("FAIL edge_op[%0d]: got v%b d%h e%b expected v1 d%h e%b", k, obs_vld[0], obs_data[0], obs_err[0], eds[k], ees[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tv_valid = 2'b01; tv_rready = 2'b00;
    tv_op[0] = C_ALU_ADD; tv_s1[0] = 32'd1; tv_s2[0] = 32'd2;
    cycle();
    tv_valid = 2'b00;
    cycle();
    n_checks++;
    if (obs_vld[0] !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b expected 1", obs_vld[0]); end
    rst = 1'b1;
    cycle();
    rst = 1'b0; tv_valid = 2'b11; tv_rready = 2'b11;
    cycle();
    n_checks++;
    if (obs_vld[0] !== 1'b0) begin n_fail++; $display("FAIL mid_discard: got %b expected 0", obs_vld[0]); end
    n_checks++;
    if (obs_rdy !== 2'b01) begin n_fail++; $display("FAIL mid_first_grant: got %b expected 01", obs_rdy); end
    tv_valid = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
        tv_valid[i]  = ($urandom_range(0, 9) < 7);
        tv_rready[i] = ($urandom_range(0, 9) < 6);
        tv_ext[i]    = 1'($urandom_range(0, 1));
        tv_op[i]     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
        tv_s1[i]     = $urandom;
        tv_s2[i]     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      end
      cycle();
      n_checks++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, obs_rdy, exp_rdy);
      end
      n_checks++;
      if (obs_vld !== exp_vld) begin
        n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, obs_vld, exp_vld);
      end
      for (int i = 0; i < 2; i++) begin
        if (exp_vld[i]) begin
          n_checks++;
          if (obs_data[i] !== exp_data[i] || obs_err[i] !== exp_err[i]) begin
            n_fail++;
            $display("FAIL rand_rsp%0d[%0d]: got d%h e%b expected d%h e%b", i, n, obs_data[i], obs_err[i], exp_data[i], exp_err[i]);
          end
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_edge_ops();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter: RR_EN, default 1, 1 = round-robin priority, 0 = fixed priority with port 0 always winning.
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have, per port i in {0,1}: req_valid_i  input  1  request present.
REQ-005 SHALL have, per port i: req_ready_i  output  1  request accepted this cycle.
REQ-006 SHALL have, per port i: req_src1_i, req_src2_i  input  32 each  ALU operands.
REQ-007 SHALL have, per port i: req_ctrl_i  input  4  ALU operation code from the shared defs.
REQ-008 SHALL have, per port i: req_ext_i  input  1  arithmetic-shift select.
REQ-009 SHALL have, per port i: rsp_valid_i  output  1  result held.
REQ-010 SHALL have, per port i: rsp_ready_i  input  1  requester consumes result.
REQ-011 SHALL have, per port i: rsp_data_i  output  32  result.
REQ-012 SHALL have, per port i: rsp_err_i  output  1  undefined op code.

Function
REQ-013 SHALL share one combinational ALU instance between the two ports; at most one request SHALL be granted per cycle.
REQ-014 Port i SHALL be eligible when req_valid_i=1 and its response slot is empty or is being drained this cycle (rsp_valid_i & rsp_ready_i).
REQ-015 req_ready_i SHALL be 1 only for the granted port; a transfer occurs on the edge where req_valid_i & req_ready_i.
REQ-016 With one eligible port, that port SHALL be granted.
REQ-017 With both ports eligible, the port indicated by the priority pointer SHALL be granted.
REQ-018 When RR_EN=1, the pointer SHALL move to the other port after every grant and SHALL be unchanged when there is no grant; when RR_EN=0, the pointer SHALL stay at port 0.
REQ-019 The ALU output SHALL be captured into the granted port's response slot on the accepting edge; rsp_valid_i SHALL be 1 in the following cycle (1-cycle latency).
REQ-020 The response slot SHALL hold rsp_data_i and rsp_err_i stable while rsp_valid_i=1 and rsp_ready_i=0.
REQ-021 On a same-edge drain and new grant, the slot SHALL load the new result and rsp_valid_i SHALL stay 1, giving one result per cycle per port.
REQ-022 A drain without a new grant SHALL clear rsp_valid_i on that edge.
REQ-023 Op codes outside the nine defined ALU codes SHALL produce rsp_data=32'h0 and rsp_err=1; defined codes SHALL produce rsp_err=0.
REQ-024 Results SHALL equal the ALU definition: ADD/SUB wrap modulo 2^32; SLT uses the sign of src1-src2 (overflow ignored, matching the ALU); SLTU is unsigned; shift amount is src2[4:0].
REQ-025 req_ready_i SHALL depend combinationally on req_valid and the slot state only, never on the operand or op-code inputs.
REQ-026 Deasserting req_valid_i before acceptance SHALL be permitted and SHALL cause no state change.

Reset
REQ-027 While rst=1: rsp_valid_0/1=0, rsp_data_0/1=32'h0, rsp_err_0/1=0, pointer=port 0, req_ready_0/1=0.
REQ-028 An in-flight or unconsumed result SHALL be discarded by reset asserted mid-operation.
REQ-029 Normal arbitration SHALL resume on the first cycle after rst falls.

Structure
REQ-030 ALU op-code constants SHALL come from the shared defs file; a port-index typedef and the count of defined codes SHALL live in the shared package alu_arb_pkg.
REQ-031 The existing ALU module SHALL be instantiated once as the sole sub-module; no second ALU copy.
REQ-032 Each response slot SHALL be 34 flops (32 data + valid + err), plus 1 pointer flop.

Verification
REQ-033 Single request: port 0 ADD 5+7 with rsp_ready_0=1 -> req_ready_0=1 same cycle; rsp_data_0=12, rsp_err_0=0 next cycle.
REQ-034 Contention, RR_EN=1, both valid for 4 cycles, rsp_ready both 1 -> grants alternate 0,1,0,1.
REQ-035 Contention, RR_EN=0 -> port 0 granted every cycle; port 1 starves.
REQ-036 Backpressure: port 1 SR ext=1 on 32'h8000_0000 by 4 with rsp_ready_1=0 -> rsp_data_1=32'hF800_0000 held and req_ready_1=0 until rsp_ready_1=1; back-to-back issue once drained.
REQ-037 Edge ops: SLT(-1,1)=1; SLTU(32'hFFFF_FFFF,1)=0; SUB 0-1=32'hFFFF_FFFF; op code 4'hF -> data 0, err 1.
REQ-038 Reset asserted while rsp_valid_0=1 -> rsp_valid_0=0 next cycle; the next simultaneous request goes to port 0.
